core_inst_sequencer: RTL and testbench



---
 rtl/core_inst_sequencer_if.sv | 26 ++
 rtl/core_inst_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_inst_sequencer_if.sv
// Host/core-facing signals of the instruction sequencer.
// The master side is the host plus core environment; the slave side is the sequencer.
interface core_inst_sequencer_if #(
  parameter int addr_w = 11
);
  logic              start;
  logic [addr_w-1:0] w_base;
  logic [addr_w-1:0] a_base;
  logic [addr_w-1:0] p_base;
  logic [addr_w-1:0] n_act;
  logic              acc_en;
  logic              ofifo_valid;
  logic [63:0]       inst;
  logic              busy;
  logic              done;

  modport master (
    output start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
    input  inst, busy, done
  );

  modport slave (
    input  start, w_base, a_base, p_base, n_act, acc_en, ofifo_valid,
    output inst, busy, done
  );
endinterface

// File: rtl/core_inst_sequencer.sv
// Issues the 64-bit core instruction word for one weight-stationary tile pass:
// weight load, activation execute, then drain of the output FIFO into psum SRAM.
module core_inst_sequencer #(
  parameter int row    = 8,
  parameter int col    = 8,
  parameter int addr_w = 11
) (
  input logic                 clk,
  input logic                 reset,
  core_inst_sequencer_if.slave bus
);

  localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;
  localparam logic [63:0] LOAD_INST = IDLE_INST | 64'h0000_0000_0000_0009;
  localparam logic [63:0] EXEC_INST = IDLE_INST | 64'h0000_0000_0000_000A;

  localparam logic [addr_w-1:0] ONE      = addr_w'(1);
  localparam logic [addr_w-1:0] ROW_CNT  = addr_w'(row);
  localparam logic [addr_w-1:0] ROW_LAST = addr_w'(row - 1);
  localparam logic [addr_w-1:0] COL_LAST = addr_w'(col - 1);

  typedef enum logic [3:0] {
    IDLE, W_RD, W_LOAD, W_GAP, A_RD, EXEC, D_WAIT, D_RD, D_WR, D_GAP, DONE
  } state_t;

  state_t            state;
  logic [addr_w-1:0] cnt;
  logic [addr_w-1:0] w_base_q;
  logic [addr_w-1:0] a_base_q;
  logic [addr_w-1:0] p_base_q;
  logic [addr_w-1:0] n_act_q;
  logic              acc_q;
  logic [63:0]       inst_q;
  logic              busy_q;
  logic              done_q;

  // SRAM-to-L0 word: l0_wr trails the read by one cycle to cover SRAM latency.
  function automatic logic [63:0] xmem_rd_word(input logic [addr_w-1:0] addr,
                                               input logic rd_en, input logic l0_wr);
    logic [63:0] w;
    w = IDLE_INST;
    if (rd_en) begin
      w[19]          = 1'b0;
      w[7 +: addr_w] = addr;
    end
    w[2] = l0_wr;
    return w;
  endfunction

  function automatic logic [63:0] pmem_word(input logic [addr_w-1:0] addr,
                                            input logic rd, input logic acc);
    logic [63:0] w;
    w               = IDLE_INST;
    w[32]           = 1'b0;
    w[20 +: addr_w] = addr;
    if (rd) begin
      w[35] = 1'b1;
    end else begin
      w[31] = 1'b0;
      w[6]  = 1'b1;
      w[33] = acc;
      w[34] = ~acc;
    end
    return w;
  endfunction

  // state/cnt describe the word currently on inst; each edge picks the next word.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      w_base_q <= '0;
      a_base_q <= '0;
      p_base_q <= '0;
      n_act_q  <= '0;
      acc_q    <= 1'b0;
      inst_q   <= IDLE_INST;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      inst_q <= IDLE_INST;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            w_base_q <= bus.w_base;
            a_base_q <= bus.a_base;
            p_base_q <= bus.p_base;
            n_act_q  <= bus.n_act;
            acc_q    <= bus.acc_en;
            busy_q   <= 1'b1;
            cnt      <= '0;
            if (bus.n_act == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state  <= W_RD;
              inst_q <= xmem_rd_word(bus.w_base, 1'b1, 1'b0);
            end
          end
        end
        W_RD: begin
          if (cnt == ROW_CNT) begin
            state  <= W_LOAD;
            cnt    <= '0;
            inst_q <= LOAD_INST;
          end else begin
            cnt    <= cnt + ONE;
            inst_q <= xmem_rd_word(w_base_q + cnt + ONE, (cnt + ONE) < ROW_CNT, 1'b1);
          end
        end
        W_LOAD: begin
          if (cnt == ROW_LAST) begin
            state <= W_GAP;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + ONE;
            inst_q <= LOAD_INST;
          end
        end
        W_GAP: begin
          if (cnt == COL_LAST) begin
            state  <= A_RD;
            cnt    <= '0;
            inst_q <= xmem_rd_word(a_base_q, 1'b1, 1'b0);
          end else begin
            cnt <= cnt + ONE;
          end
        end
        A_RD: begin
          if (cnt == n_act_q) begin
            state  <= EXEC;
            cnt    <= '0;
            inst_q <= EXEC_INST;
          end else begin
            cnt    <= cnt + ONE;
            inst_q <= xmem_rd_word(a_base_q + cnt + ONE, (cnt + ONE) < n_act_q, 1'b1);
          end
        end
        EXEC: begin
          if (cnt == n_act_q - ONE) begin
            state <= D_WAIT;
            cnt   <= '0;
          end else begin
            cnt    <= cnt + ONE;
            inst_q <= EXEC_INST;
          end
        end
        // cnt is now the output index k; valid is only trusted in D_WAIT.
        D_WAIT: begin
          if (bus.ofifo_valid) begin
            if (acc_q) begin
              state  <= D_RD;
              inst_q <= pmem_word(p_base_q + cnt, 1'b1, 1'b1);
            end else begin
              state  <= D_WR;
              inst_q <= pmem_word(p_base_q + cnt, 1'b0, 1'b0);
            end
          end
        end
        D_RD: begin
          state  <= D_WR;
          inst_q <= pmem_word(p_base_q + cnt, 1'b0, 1'b1);
        end
        D_WR: begin
          state <= D_GAP;
        end
        D_GAP: begin
          if (cnt == n_act_q - ONE) begin
            state  <= DONE;
            done_q <= 1'b1;
          end else begin
            state <= D_WAIT;
            cnt   <= cnt + ONE;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst = inst_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Scoreboard bench for core_inst_sequencer: expected per-cycle words are queued at start
// from the pass description and popped against the DUT every cycle.
module tb_core_inst_sequencer;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int AW  = 11;
  localparam logic [63:0] IDLE_INST = 64'h0000_0001_800C_0000;

  typedef struct packed {
    logic [63:0] inst;
    logic        busy;
    logic        done;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   stall_start = -1;
  int   stall_len = 0;

  core_inst_sequencer_if #(.addr_w(AW)) bus ();

  core_inst_sequencer #(.row(ROW), .col(COL), .addr_w(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xrd_word(input logic [AW-1:0] a, input bit rd, input bit l0w);
    logic [63:0] w;
    w = IDLE_INST;
    if (rd) begin
      w[19]   = 1'b0;
      w[17:7] = a;
    end
    w[2] = l0w;
    return w;
  endfunction

  task automatic push(input logic [63:0] w, input logic d);
    exp_t e;
    e.inst = w;
    e.busy = 1'b1;
    e.done = d;
    exp_q.push_back(e);
  endtask

  // Expected words, one per cycle starting the cycle after start is sampled.
  task automatic build_expected(input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                                input logic [AW-1:0] pb, input int nn, input bit acc,
                                input int stall_k, input int stall_n);
    logic [63:0] w;
    logic [AW-1:0] pa;
    exp_q.delete();
    stall_start = -1;
    stall_len   = stall_n;
    if (nn == 0) begin
      push(IDLE_INST, 1'b1);
      return;
    end
    for (int i = 0; i <= ROW; i++) push(xrd_word(wb + AW'(i), i < ROW, i >= 1), 1'b0);
    for (int i = 0; i < ROW; i++) push(IDLE_INST | 64'h9, 1'b0);
    for (int i = 0; i < COL; i++) push(IDLE_INST, 1'b0);
    for (int i = 0; i <= nn; i++) push(xrd_word(ab + AW'(i), i < nn, i >= 1), 1'b0);
    for (int i = 0; i < nn; i++) push(IDLE_INST | 64'hA, 1'b0);
    for (int k = 0; k < nn; k++) begin
      if (k == stall_k) begin
        stall_start = exp_q.size() + 1;
        for (int s = 0; s < stall_n; s++) push(IDLE_INST, 1'b0);
      end
      push(IDLE_INST, 1'b0);
      pa = pb + AW'(k);
      if (acc) begin
        w = IDLE_INST;
        w[32] = 1'b0;
        w[35] = 1'b1;
        w[30:20] = pa;
        push(w, 1'b0);
      end
      w = IDLE_INST;
      w[32] = 1'b0;
      w[31] = 1'b0;
      w[6]  = 1'b1;
      w[30:20] = pa;
      if (acc) w[33] = 1'b1;
      else     w[34] = 1'b1;
      push(w, 1'b0);
      push(IDLE_INST, 1'b0);
    end
    push(IDLE_INST, 1'b1);
  endtask

  task automatic run_pass(input string name, input logic [AW-1:0] wb, input logic [AW-1:0] ab,
                          input logic [AW-1:0] pb, input int nn, input bit acc,
                          input int stall_k, input int stall_n, input int abort_at,
                          input int busy_start_at);
    exp_t e;
    int cyc;
    int loads, execs, ordd, clash;
    bit aborted;
    loads = 0; execs = 0; ordd = 0; clash = 0; aborted = 1'b0;
    build_expected(wb, ab, pb, nn, acc, stall_k, stall_n);
    @(negedge clk);
    bus.w_base = wb;
    bus.a_base = ab;
    bus.p_base = pb;
    bus.n_act  = AW'(nn);
    bus.acc_en = acc;
    bus.ofifo_valid = 1'b1;
    bus.start  = 1'b1;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == busy_start_at);
      if (cyc == busy_start_at) begin
        bus.w_base = ~wb;
        bus.a_base = ~ab;
        bus.p_base = ~pb;
        bus.n_act  = AW'(nn + 3);
        bus.acc_en = ~acc;
      end
      bus.ofifo_valid = !(stall_start >= 0 && cyc >= stall_start && cyc < stall_start + stall_len);
      if (cyc == abort_at) begin
        reset = 1'b1;
        aborted = 1'b1;
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      compared++;
      if (bus.inst !== e.inst || bus.busy !== e.busy || bus.done !== e.done) begin
        mismatched++;
        $display("[TB] FAIL %s cycle %0d: got inst=%h busy=%b done=%b, want inst=%h busy=%b done=%b",
                 name, cyc, bus.inst, bus.busy, bus.done, e.inst, e.busy, e.done);
      end
      loads += int'(bus.inst[0]);
      execs += int'(bus.inst[1]);
      ordd  += int'(bus.inst[6]);
      clash += int'(bus.inst[35] && !bus.inst[31]);
    end
    @(negedge clk);
    bus.start = 1'b0;
    bus.ofifo_valid = 1'b1;
    compared++;
    if (bus.inst !== IDLE_INST || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL %s after: got inst=%h busy=%b done=%b, want inst=%h busy=0 done=0",
               name, bus.inst, bus.busy, bus.done, IDLE_INST);
    end
    reset = 1'b0;
    if (!aborted) begin
      compared++;
      if (loads != ((nn == 0) ? 0 : ROW) || execs != nn || ordd != nn || clash != 0) begin
        mismatched++;
        $display("[TB] FAIL %s counts: got load=%0d exec=%0d ofifo_rd=%0d ren_wen=%0d, want %0d %0d %0d 0",
                 name, loads, execs, ordd, clash, (nn == 0) ? 0 : ROW, nn, nn);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.w_base = '0;
    bus.a_base = '0;
    bus.p_base = '0;
    bus.n_act  = '0;
    bus.acc_en = 1'b0;
    bus.ofifo_valid = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (bus.inst !== IDLE_INST || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset: got inst=%h busy=%b done=%b, want inst=%h busy=0 done=0",
               bus.inst, bus.busy, bus.done, IDLE_INST);
    end
    reset = 1'b0;
  endtask

  task automatic test_passthrough();
    run_pass("passthrough", 11'd0, 11'd16, 11'd0, 4, 1'b0, -1, 0, -1, -1);
  endtask

  task automatic test_accumulate();
    run_pass("accumulate", 11'd0, 11'd16, 11'd0, 4, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_drain_stall();
    run_pass("stall_acc", 11'd0, 11'd16, 11'd0, 4, 1'b1, 1, 20, -1, -1);
    run_pass("stall_pass", 11'd3, 11'd40, 11'd7, 3, 1'b0, 0, 20, -1, -1);
  endtask

  task automatic test_wrap();
    run_pass("wrap", 11'd2046, 11'd2045, 11'd2046, 5, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_reset_exec();
    // EXEC occupies cycles 31..34 of a 4-vector pass.
    run_pass("abort_exec", 11'd0, 11'd16, 11'd0, 4, 1'b0, -1, 0, 32, -1);
    run_pass("after_abort", 11'd100, 11'd200, 11'd300, 4, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_zero_n();
    run_pass("zero_n", 11'd5, 11'd6, 11'd7, 0, 1'b1, -1, 0, -1, -1);
  endtask

  task automatic test_busy_start();
    run_pass("busy_start", 11'd10, 11'd30, 11'd50, 2, 1'b0, -1, 0, -1, 5);
  endtask

  task automatic test_back_to_back();
    run_pass("b2b_a", 11'd1, 11'd2, 11'd3, 1, 1'b0, -1, 0, -1, -1);
    run_pass("b2b_b", 11'd9, 11'd20, 11'd40, 6, 1'b1, -1, 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_accumulate();
    test_drain_stall();
    test_wrap();
    test_reset_exec();
    test_zero_n();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
